// File: rtl/dmem_responder.sv
// Data-memory responder: the slave end of the core's load/store port.
// A request is accepted in IDLE, held for WAIT_CYCLES wait states, committed
// (error check, array write or load extract) on the edge entering RESP, and
// presented until the requester takes it.
// Ports:
//   clk_i, rst_i           clock (rising edge), async active-low reset
//   req_valid_i/ready_o    request handshake
//   req_write_i            1 = store, 0 = load
//   req_addr_i             byte address
//   req_wdata_i            store data, byte/half taken from the low bits
//   req_size_i             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i         loads: 1 = zero-extend, 0 = sign-extend
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            extended load data, 0 for stores and errors
//   rsp_err_o              misaligned, out-of-range or illegal-size request
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               lat_write_q, lat_write_d;
  logic [31:0]        lat_addr_q, lat_addr_d;
  logic [31:0]        lat_wdata_q, lat_wdata_d;
  logic [1:0]         lat_size_q, lat_size_d;
  logic               lat_uns_q, lat_uns_d;

  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               accept_c;
  logic               commit_c;

  // Operand seen by the commit logic: live inputs when committing straight
  // out of IDLE (no wait states), latched request otherwise.
  logic               cur_write_c;
  logic [31:0]        cur_addr_c;
  logic [31:0]        cur_wdata_c;
  logic [1:0]         cur_size_c;
  logic               cur_uns_c;

  logic [1:0]         lane_c;
  logic [IDX_W-1:0]   idx_c;
  logic               err_c;
  logic [31:0]        word_c;
  logic [31:0]        shifted_c;
  logic [31:0]        load_c;
  logic [3:0]         be_c;
  logic [31:0]        wsh_c;
  logic [31:0]        merge_c;
  logic               mem_we_c;

  logic [31:0]        mem_q [DEPTH_WORDS];

  assign accept_c = (state_q == S_IDLE) && req_valid_i && req_ready_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; commit_c marks the single edge that enters RESP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Commit operand select
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_write_c = req_write_i;
      cur_addr_c  = req_addr_i;
      cur_wdata_c = req_wdata_i;
      cur_size_c  = req_size_i;
      cur_uns_c   = req_unsigned_i;
    end else begin
      cur_write_c = lat_write_q;
      cur_addr_c  = lat_addr_q;
      cur_wdata_c = lat_wdata_q;
      cur_size_c  = lat_size_q;
      cur_uns_c   = lat_uns_q;
    end
  end

  // Error check, load extract/extend and store byte-lane merge
  always_comb begin
    lane_c    = cur_addr_c[1:0];
    idx_c     = cur_addr_c[IDX_W+1:2];
    err_c     = (cur_size_c == 2'b11)
              | ((cur_size_c == 2'b01) & cur_addr_c[0])
              | ((cur_size_c == 2'b10) & (|cur_addr_c[1:0]))
              | ({2'b00, cur_addr_c[31:2]} >= 32'(DEPTH_WORDS));
    word_c    = mem_q[idx_c];
    shifted_c = word_c >> {lane_c, 3'b000};
    load_c    = word_c;
    be_c      = 4'b1111;
    unique case (cur_size_c)
      2'b00: begin
        load_c = {{24{~cur_uns_c & shifted_c[7]}}, shifted_c[7:0]};
        be_c   = 4'b0001 << lane_c;
      end
      2'b01: begin
        load_c = {{16{~cur_uns_c & shifted_c[15]}}, shifted_c[15:0]};
        be_c   = 4'b0011 << lane_c;
      end
      default: begin
        load_c = word_c;
        be_c   = 4'b1111;
      end
    endcase
    wsh_c   = cur_wdata_c << {lane_c, 3'b000};
    merge_c = word_c;
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) begin
        merge_c[8*i +: 8] = wsh_c[8*i +: 8];
      end
    end
    mem_we_c = commit_c & cur_write_c & ~err_c;
  end

  // Output / request-latch logic
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_size_d  = lat_size_q;
    lat_uns_d   = lat_uns_q;
    if (accept_c) begin
      lat_write_d = req_write_i;
      lat_addr_d  = req_addr_i;
      lat_wdata_d = req_wdata_i;
      lat_size_d  = req_size_i;
      lat_uns_d   = req_unsigned_i;
    end
    if (commit_c) begin
      rsp_err_d   = err_c;
      rsp_rdata_d = (err_c | cur_write_c) ? 32'h0 : load_c;
    end else if (state_d == S_IDLE) begin
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
    end
  end

  // Output and request-latch registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 32'h0;
      lat_wdata_q <= 32'h0;
      lat_size_q  <= 2'b00;
      lat_uns_q   <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_size_q  <= lat_size_d;
      lat_uns_q   <= lat_uns_d;
    end
  end

  // Storage array: not reset, written only on a committed, error-free store
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= merge_c;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance (u_dut) and a
// WAIT_CYCLES=0 instance (u_dut_z), each with a reference model and a
// queue of expected responses popped on every response handshake.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 128;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;

  logic        req_valid_z, req_ready_z, req_write_z, req_unsigned_z;
  logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
  logic [1:0]  req_size_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_err_z;

  exp_t        q_a[$];
  exp_t        q_z[$];
  logic [31:0] model [2][DEPTH];
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_unsigned_i(req_unsigned),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_z (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_z), .req_ready_o(req_ready_z), .req_write_i(req_write_z),
    .req_addr_i(req_addr_z), .req_wdata_i(req_wdata_z), .req_size_i(req_size_z),
    .req_unsigned_i(req_unsigned_z),
    .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z), .rsp_rdata_o(rsp_rdata_z),
    .rsp_err_o(rsp_err_z)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of one access; updates model[s] on a legal store
  function automatic exp_t model_acc(input int s, input bit w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [1:0] sz, input bit u);
    exp_t        r;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    int          wi;
    int          lane;
    r.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || (a >= 32'(4 * DEPTH));
    r.rdata = 32'h0;
    if (r.err) return r;
    wi   = int'(a >> 2);
    lane = int'(a[1:0]);
    word = model[s][wi];
    if (w) begin
      case (sz)
        2'b00:   word[8*lane +: 8] = d[7:0];
        2'b01:   word[8*lane +: 16] = d[15:0];
        default: word = d;
      endcase
      model[s][wi] = word;
    end else begin
      case (sz)
        2'b00: begin
          b = word[8*lane +: 8];
          r.rdata = u ? {24'h0, b} : {{24{b[7]}}, b};
        end
        2'b01: begin
          h = word[8*lane +: 16];
          r.rdata = u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: r.rdata = word;
      endcase
    end
    return r;
  endfunction

  // Response scoreboards
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid && rsp_ready) begin
      if (q_a.size() == 0) begin
        check_val("a_unexpected_rsp", 32'(q_a.size()), 32'd1);
      end else begin
        e = q_a.pop_front();
        check_val("a_rdata", rsp_rdata, e.rdata);
        check_val("a_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid_z && rsp_ready_z) begin
      if (q_z.size() == 0) begin
        check_val("z_unexpected_rsp", 32'(q_z.size()), 32'd1);
      end else begin
        e = q_z.pop_front();
        check_val("z_rdata", rsp_rdata_z, e.rdata);
        check_val("z_err", 32'(rsp_err_z), 32'(e.err));
      end
    end
  end

  // Issue one request to u_dut; scrambles the inputs once it is accepted
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit u);
    int n;
    q_a.push_back(model_acc(0, w, a, d, sz, u));
    req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_val("a_req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_a.size() != 0 || rsp_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_val("a_idle_timeout", 32'(q_a.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int acc_prev;
    exp_t e;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b1;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
    req_size_z = 2'b00; req_unsigned_z = 1'b0; rsp_ready_z = 1'b1;

    #12;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Word store then load, with response latency measured from the request cycle
    send(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    wait_idle();
    q_a.push_back(model_acc(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0));
    req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
    check_val("a_latency", 32'(lat), 32'd3);

    // Byte lanes and extension
    send(1'b1, 32'h11, 32'hABCDEF80, 2'b00, 1'b0);
    send(1'b0, 32'h11, 32'h0, 2'b00, 1'b0);
    send(1'b0, 32'h11, 32'h0, 2'b00, 1'b1);
    send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);

    // Errors: misaligned, out of range, illegal size
    send(1'b0, 32'h13, 32'h0, 2'b01, 1'b0);
    send(1'b0, 32'(4 * DEPTH), 32'h0, 2'b10, 1'b0);
    send(1'b1, 32'h202, 32'h55555555, 2'b10, 1'b0);
    send(1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
    send(1'b0, 32'h10, 32'h0, 2'b11, 1'b0);

    // Halfwords and the last legal word
    send(1'b1, 32'h14, 32'h11112222, 2'b10, 1'b0);
    send(1'b1, 32'h16, 32'hFFFF8001, 2'b01, 1'b0);
    send(1'b0, 32'h16, 32'h0, 2'b01, 1'b0);
    send(1'b0, 32'h16, 32'h0, 2'b01, 1'b1);
    send(1'b0, 32'h14, 32'h0, 2'b10, 1'b0);
    send(1'b1, 32'h1FC, 32'h7F001234, 2'b10, 1'b0);
    send(1'b0, 32'h1FF, 32'h0, 2'b00, 1'b0);
    send(1'b0, 32'h1FC, 32'h0, 2'b00, 1'b0);
    send(1'b0, 32'h1FE, 32'h0, 2'b01, 1'b1);

    // Response back-pressure
    wait_idle();
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("a_hold_reach", 32'(rsp_valid), 32'd1);
    e = q_a[0];
    repeat (5) begin
      @(negedge clk);
      check_val("a_hold_valid", 32'(rsp_valid), 32'd1);
      check_val("a_hold_rdata", rsp_rdata, e.rdata);
      check_val("a_hold_err", 32'(rsp_err), 32'(e.err));
      check_val("a_hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("a_release_req_ready", 32'(req_ready), 32'd1);
    check_val("a_release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset during the wait states of a store discards it
    send(1'b1, 32'h20, 32'hA5A5A5A5, 2'b10, 1'b0);
    wait_idle();
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_val("a_mid_wait_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_val("a_mid_rst_req_ready", 32'(req_ready), 32'd1);
    check_val("a_mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("a_mid_rst_rdata", rsp_rdata, 32'h0);
    check_val("a_mid_rst_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);

    // Zero-wait instance: back-to-back requests, one accept every 2 cycles
    acc_prev = 0;
    for (int i = 0; i < 8; i++) begin
      req_write_z    = (i < 4);
      req_addr_z     = 32'(4 * (i % 4));
      req_wdata_z    = $urandom;
      req_size_z     = 2'b10;
      req_unsigned_z = 1'b0;
      q_z.push_back(model_acc(1, req_write_z, req_addr_z, req_wdata_z, req_size_z, 1'b0));
      req_valid_z = 1'b1;
      n = 0;
      while (!req_ready_z && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 20) check_val("z_req_ready_timeout", 32'(req_ready_z), 32'd1);
      @(posedge clk); #1;
      if (i > 0) check_val("z_spacing", 32'(cyc - acc_prev), 32'd2);
      acc_prev = cyc;
    end
    req_valid_z = 1'b0;

    n = 0;
    while ((q_a.size() != 0 || q_z.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("a_queue_left", 32'(q_a.size()), 32'd0);
    check_val("z_queue_left", 32'(q_z.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
